// File: rtl/fetch_instr_queue_pkg.sv
// Shared fetch-queue definitions: entry layout,
// default depth, bus width and fetch vectors.
package fetch_instr_queue_pkg;

  localparam int INSTRBUS_WIDTH = 32;
  localparam int FIQ_DEPTH      = 4;
  localparam int FIQ_ENTRY_W    = 2 * INSTRBUS_WIDTH + 1;

  // Fetch vectors a flush redirects to.
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h8000_0180;

  typedef struct packed {
    logic [INSTRBUS_WIDTH-1:0] pc;
    logic [INSTRBUS_WIDTH-1:0] instr;
    logic                      exc;
  } fiq_entry_t;

  function automatic fiq_entry_t fiq_pack(
    input logic [INSTRBUS_WIDTH-1:0] pc,
    input logic [INSTRBUS_WIDTH-1:0] instr,
    input logic                      exc
  );
    fiq_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    e.exc   = exc;
    return e;
  endfunction

endpackage

// File: rtl/fetch_instr_queue.sv
// Fetch-to-decode instruction FIFO with flush.
// Ports: clk, reset (async high), flush;
//   in_valid/in_ready/in_pc/in_instr/in_exc from fetch;
//   out_valid/out_ready/out_pc/out_instr/out_exc to
//   decode; count = occupied entries.
module fetch_instr_queue
  import fetch_instr_queue_pkg::*;
#(
  parameter int DEPTH = FIQ_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  input  logic          in_exc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic          out_exc,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fiq_entry_t mem [DEPTH];
  fiq_entry_t head;

  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;

  // Full queue never accepts, even with a
  // same-cycle pop: keeps in_ready registered-only.
  assign in_ready  = (cnt != FULL);
  assign out_valid = (cnt != '0);
  assign count     = cnt;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign head = mem[rp];

  // Empty queue presents a nop with clean side fields.
  always_comb begin
    out_pc    = 32'h0;
    out_instr = 32'h0;
    out_exc   = 1'b0;
    if (out_valid) begin
      out_pc    = head.pc;
      out_instr = head.instr;
      out_exc   = head.exc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= fiq_pack(in_pc, in_instr, in_exc);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
